wb_stage: RTL and testbench

- Final pipeline stage, directly downstream of the memory-access stage; consumes its 43-bit MEM_WB_BUS plus its address-error flags.
- Holds a one-entry WB pipeline register and drives the register-file write port.
- Owns the HI/LO registers and a minimal CP0 (Status, Cause, EPC, BadVAddr).
- Commits exceptions and ERET as a one-cycle pipeline flush, and counts retired instructions.

---
 rtl/wb_stage.sv | 218 +++++++++++++++++++++
 tb/tb_wb_stage.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - writeback stage: WB register, register-file write port, HI/LO, minimal CP0 and flush
// Exceptions and ERET retire as a single FLUSH cycle that redirects the front end.
module wb_stage #(
   parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
   parameter logic [31:0] STATUS_RESET = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [42:0] MEM_WB_BUS,
   input  logic        mem_valid,
   input  logic        adel,
   input  logic        ades,
   input  logic [31:0] epc,
   input  logic [31:0] e_addr,
   output logic        wb_allow_in,
   output logic        rf_wen,
   output logic [4:0]  rf_wdest,
   output logic [31:0] rf_wdata,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] cp0_status,
   output logic [31:0] cp0_cause,
   output logic [31:0] cp0_epc,
   output logic        flush,
   output logic [31:0] flush_pc,
   output logic [31:0] retired
);

   typedef enum logic {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_t;

   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_SYS  = 5'd8;

   state_t      state_q, state_d;
   logic        wb_valid_q, wb_valid_d;
   logic [42:0] bus_q, bus_d;
   logic        adel_q, adel_d;
   logic        ades_q, ades_d;
   logic [31:0] epc_q, epc_d;
   logic [31:0] eaddr_q, eaddr_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic [31:0] status_q, status_d;
   logic [31:0] cause_q, cause_d;
   logic [31:0] cp0_epc_q, cp0_epc_d;
   logic [31:0] badvaddr_q, badvaddr_d;
   logic [31:0] retired_q, retired_d;
   logic [31:0] flush_pc_q, flush_pc_d;

   logic        f_rf_wen;
   logic [4:0]  f_wdest;
   logic        f_cp0_wen;
   logic        f_hi_wen;
   logic        f_lo_wen;
   logic        f_syscall;
   logic        f_eret;
   logic [31:0] f_result;

   logic        exc;
   logic        eret_take;
   logic        commit;
   logic        capture;
   logic        go_flush;
   logic [4:0]  exc_code;

   assign {f_rf_wen, f_wdest, f_cp0_wen, f_hi_wen, f_lo_wen, f_syscall, f_eret, f_result} = bus_q;

   assign exc       = wb_valid_q & (adel_q | ades_q | f_syscall);
   assign eret_take = wb_valid_q & f_eret & ~exc;
   assign commit    = wb_valid_q & ~exc & ~f_eret;
   assign capture   = mem_valid & wb_allow_in;
   assign go_flush  = (state_q == ST_RUN) & (state_d == ST_FLUSH);

   always_comb begin
      exc_code = EXC_SYS;
      if (adel_q) begin
         exc_code = EXC_ADEL;
      end else if (ades_q) begin
         exc_code = EXC_ADES;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN: begin
            if (wb_valid_q & (exc | eret_take)) begin
               state_d = ST_FLUSH;
            end
         end
         ST_FLUSH: state_d = ST_RUN;
         default:  state_d = ST_RUN;
      endcase
   end

   always_comb begin
      wb_allow_in = (state_q == ST_RUN);
      flush       = (state_q == ST_FLUSH);
   end

   always_comb begin
      wb_valid_d = capture;
      bus_d      = bus_q;
      adel_d     = adel_q;
      ades_d     = ades_q;
      epc_d      = epc_q;
      eaddr_d    = eaddr_q;
      if (capture) begin
         bus_d   = MEM_WB_BUS;
         adel_d  = adel;
         ades_d  = ades;
         epc_d   = epc;
         eaddr_d = e_addr;
      end
   end

   // Architectural state: software writes only on commit, hardware writes on exception/ERET.
   always_comb begin
      hi_d       = hi_q;
      lo_d       = lo_q;
      status_d   = status_q;
      cause_d    = cause_q;
      cp0_epc_d  = cp0_epc_q;
      badvaddr_d = badvaddr_q;
      retired_d  = retired_q;
      flush_pc_d = 32'h0;

      if (commit) begin
         retired_d = retired_q + 32'd1;
         if (f_hi_wen) begin
            hi_d = f_result;
         end
         if (f_lo_wen) begin
            lo_d = f_result;
         end
         if (f_cp0_wen) begin
            case (f_wdest)
               5'd12:   status_d = f_result;
               5'd13:   cause_d[9:8] = f_result[9:8];
               5'd14:   cp0_epc_d = f_result;
               default: ;
            endcase
         end
      end

      if (exc) begin
         cause_d[6:2] = exc_code;
         status_d[1]  = 1'b1;
         if (!status_q[1]) begin
            cp0_epc_d = epc_q;
         end
         if (adel_q | ades_q) begin
            badvaddr_d = eaddr_q;
         end
      end else if (eret_take) begin
         status_d[1] = 1'b0;
      end

      if (go_flush) begin
         flush_pc_d = exc ? EXC_VECTOR : cp0_epc_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         wb_valid_q <= 1'b0;
         bus_q      <= '0;
         adel_q     <= 1'b0;
         ades_q     <= 1'b0;
         epc_q      <= '0;
         eaddr_q    <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         status_q   <= STATUS_RESET;
         cause_q    <= '0;
         cp0_epc_q  <= '0;
         badvaddr_q <= '0;
         retired_q  <= '0;
         flush_pc_q <= '0;
      end else begin
         wb_valid_q <= wb_valid_d;
         bus_q      <= bus_d;
         adel_q     <= adel_d;
         ades_q     <= ades_d;
         epc_q      <= epc_d;
         eaddr_q    <= eaddr_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         status_q   <= status_d;
         cause_q    <= cause_d;
         cp0_epc_q  <= cp0_epc_d;
         badvaddr_q <= badvaddr_d;
         retired_q  <= retired_d;
         flush_pc_q <= flush_pc_d;
      end
   end

   assign rf_wen     = commit & f_rf_wen;
   assign rf_wdest   = f_wdest;
   assign rf_wdata   = f_result;
   assign hi         = hi_q;
   assign lo         = lo_q;
   assign cp0_status = status_q;
   assign cp0_cause  = cause_q;
   assign cp0_epc    = cp0_epc_q;
   assign flush_pc   = flush_pc_q;
   assign retired    = retired_q;

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - self-checking bench for wb_stage
module tb_wb_stage;

   localparam logic [31:0] VEC = 32'hBFC0_0380;
   localparam logic [31:0] DB  = 32'hDEAD_BEEF;
   localparam logic [31:0] E1  = 32'hBFC0_0100;
   localparam logic [31:0] P   = 32'h8000_0040;

   logic        clk = 1'b0;
   logic        resetn;
   logic [42:0] MEM_WB_BUS;
   logic        mem_valid, adel, ades;
   logic [31:0] epc, e_addr;
   logic        wb_allow_in, rf_wen, flush;
   logic [4:0]  rf_wdest;
   logic [31:0] rf_wdata, hi, lo, cp0_status, cp0_cause, cp0_epc, flush_pc, retired;

   int checks = 0;
   int failures = 0;

   wb_stage dut (
      .clk(clk), .resetn(resetn), .MEM_WB_BUS(MEM_WB_BUS), .mem_valid(mem_valid),
      .adel(adel), .ades(ades), .epc(epc), .e_addr(e_addr),
      .wb_allow_in(wb_allow_in), .rf_wen(rf_wen), .rf_wdest(rf_wdest), .rf_wdata(rf_wdata),
      .hi(hi), .lo(lo), .cp0_status(cp0_status), .cp0_cause(cp0_cause), .cp0_epc(cp0_epc),
      .flush(flush), .flush_pc(flush_pc), .retired(retired)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic        mv;
      logic [42:0] bus;
      logic        adel, ades;
      logic [31:0] epc, eaddr;
      logic        rfw;
      logic [4:0]  wdest;
      logic [31:0] wdata, hi, lo, st, ca, ep;
      logic        fl;
      logic [31:0] fpc, ret;
   } vec_t;

   vec_t tbl[27];

   // Architectural reference: one instruction slot plus programmer-visible state.
   logic        s_valid, s_adel, s_ades;
   logic [42:0] s_bus;
   logic [31:0] s_epc, s_eaddr;
   logic [31:0] m_hi, m_lo, m_status, m_cause, m_epc, m_bad, m_ret, m_fpc;
   logic        m_flushing;

   function automatic logic [42:0] mkb(input logic rfw, input logic [4:0] dest, input logic cp0,
                                       input logic hw, input logic lw, input logic sys,
                                       input logic er, input logic [31:0] res);
      return {rfw, dest, cp0, hw, lw, sys, er, res};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic model_edge();
      logic is_exc, is_eret, is_commit, next_fl;
      logic [31:0] target;
      if (!resetn) begin
         s_valid = 0; s_bus = '0; s_adel = 0; s_ades = 0; s_epc = 0; s_eaddr = 0;
         m_hi = 0; m_lo = 0; m_status = 0; m_cause = 0; m_epc = 0; m_bad = 0; m_ret = 0;
         m_fpc = 0; m_flushing = 0;
         return;
      end
      is_exc    = s_valid && (s_adel || s_ades || s_bus[33]);
      is_eret   = s_valid && s_bus[32] && !is_exc;
      is_commit = s_valid && !is_exc && !s_bus[32];
      next_fl   = !m_flushing && (is_exc || is_eret);
      target    = is_exc ? VEC : m_epc;
      if (is_exc) begin
         m_cause[6:2] = s_adel ? 5'd4 : (s_ades ? 5'd5 : 5'd8);
         if (m_status[1] == 1'b0) m_epc = s_epc;
         m_status[1] = 1'b1;
         if (s_adel || s_ades) m_bad = s_eaddr;
      end
      if (is_eret) m_status[1] = 1'b0;
      if (is_commit) begin
         m_ret = m_ret + 1;
         if (s_bus[35]) m_hi = s_bus[31:0];
         if (s_bus[34]) m_lo = s_bus[31:0];
         if (s_bus[36]) begin
            if (s_bus[41:37] == 5'd12) m_status = s_bus[31:0];
            if (s_bus[41:37] == 5'd13) m_cause[9:8] = s_bus[9:8];
            if (s_bus[41:37] == 5'd14) m_epc = s_bus[31:0];
         end
      end
      s_valid = mem_valid && !m_flushing;
      if (s_valid) begin
         s_bus = MEM_WB_BUS; s_adel = adel; s_ades = ades; s_epc = epc; s_eaddr = e_addr;
      end
      m_flushing = next_fl;
      m_fpc = next_fl ? target : 32'h0;
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic check_model();
      logic e_rfw;
      e_rfw = s_valid && !(s_adel || s_ades || s_bus[33]) && !s_bus[32] && s_bus[42];
      chk("m_rf_wen", rf_wen, e_rfw);
      if (e_rfw) begin
         chk("m_rf_wdest", rf_wdest, s_bus[41:37]);
         chk("m_rf_wdata", rf_wdata, s_bus[31:0]);
      end
      chk("m_hi", hi, m_hi);
      chk("m_lo", lo, m_lo);
      chk("m_status", cp0_status, m_status);
      chk("m_cause", cp0_cause, m_cause);
      chk("m_epc", cp0_epc, m_epc);
      chk("m_flush", flush, m_flushing);
      chk("m_allow", wb_allow_in, !m_flushing);
      chk("m_retired", retired, m_ret);
      if (m_flushing) chk("m_flush_pc", flush_pc, m_fpc);
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_rf_wen"}, rf_wen, 0);
      chk({tag, "_flush"}, flush, 0);
      chk({tag, "_flush_pc"}, flush_pc, 0);
      chk({tag, "_allow"}, wb_allow_in, 1);
      chk({tag, "_hi"}, hi, 0);
      chk({tag, "_lo"}, lo, 0);
      chk({tag, "_status"}, cp0_status, 0);
      chk({tag, "_cause"}, cp0_cause, 0);
      chk({tag, "_epc"}, cp0_epc, 0);
      chk({tag, "_retired"}, retired, 0);
   endtask

   task automatic idle();
      mem_valid = 0; MEM_WB_BUS = '0; adel = 0; ades = 0; epc = 0; e_addr = 0;
   endtask

   initial begin
      tbl[0]  = '{1, mkb(1,5,0,0,0,0,0,32'h12345678), 0,0, 0,0, 1,5,32'h12345678, 0,0, 0,0,0, 0,0, 0};
      tbl[1]  = '{0, '0, 0,0, 0,0, 0,0,0, 0,0, 0,0,0, 0,0, 1};
      tbl[2]  = '{1, mkb(0,0,0,1,1,0,0,DB), 0,0, 0,0, 0,0,0, 0,0, 0,0,0, 0,0, 1};
      tbl[3]  = '{0, '0, 0,0, 0,0, 0,0,0, DB,DB, 0,0,0, 0,0, 2};
      tbl[4]  = '{1, mkb(1,3,0,0,0,0,0,0), 1,0, E1,32'h1003, 0,0,0, DB,DB, 0,0,0, 0,0, 2};
      tbl[5]  = '{0, '0, 0,0, 0,0, 0,0,0, DB,DB, 2,32'h10,E1, 1,VEC, 2};
      tbl[6]  = '{1, mkb(1,7,0,0,0,0,0,32'h77), 0,0, 0,0, 0,0,0, DB,DB, 2,32'h10,E1, 0,0, 2};
      tbl[7]  = '{1, mkb(0,0,0,0,0,1,0,0), 0,0, 32'h80001234,0, 0,0,0, DB,DB, 2,32'h10,E1, 0,0, 2};
      tbl[8]  = '{0, '0, 0,0, 0,0, 0,0,0, DB,DB, 2,32'h20,E1, 1,VEC, 2};
      tbl[9]  = '{0, '0, 0,0, 0,0, 0,0,0, DB,DB, 2,32'h20,E1, 0,0, 2};
      tbl[10] = '{1, mkb(0,0,0,0,0,0,1,0), 0,0, 0,0, 0,0,0, DB,DB, 2,32'h20,E1, 0,0, 2};
      tbl[11] = '{0, '0, 0,0, 0,0, 0,0,0, DB,DB, 0,32'h20,E1, 1,E1, 2};
      tbl[12] = '{0, '0, 0,0, 0,0, 0,0,0, DB,DB, 0,32'h20,E1, 0,0, 2};
      tbl[13] = '{1, mkb(0,14,1,0,0,0,0,P), 0,0, 0,0, 0,0,0, DB,DB, 0,32'h20,E1, 0,0, 2};
      tbl[14] = '{1, mkb(0,0,0,0,0,0,1,0), 0,0, 0,0, 0,0,0, DB,DB, 0,32'h20,P, 0,0, 3};
      tbl[15] = '{0, '0, 0,0, 0,0, 0,0,0, DB,DB, 0,32'h20,P, 1,P, 3};
      tbl[16] = '{0, '0, 0,0, 0,0, 0,0,0, DB,DB, 0,32'h20,P, 0,0, 3};
      tbl[17] = '{1, mkb(0,13,1,0,0,0,0,32'hFFFFFFFF), 0,0, 0,0, 0,0,0, DB,DB, 0,32'h20,P, 0,0, 3};
      tbl[18] = '{1, mkb(0,8,1,0,0,0,0,32'hFFFFFFFF), 0,0, 0,0, 0,0,0, DB,DB, 0,32'h320,P, 0,0, 4};
      tbl[19] = '{1, mkb(0,0,0,0,0,0,0,0), 0,1, 32'h100,32'h2002, 0,0,0, DB,DB, 0,32'h320,P, 0,0, 5};
      tbl[20] = '{0, '0, 0,0, 0,0, 0,0,0, DB,DB, 2,32'h314,32'h100, 1,VEC, 5};
      tbl[21] = '{0, '0, 0,0, 0,0, 0,0,0, DB,DB, 2,32'h314,32'h100, 0,0, 5};
      tbl[22] = '{1, mkb(1,12,1,0,0,0,0,32'hFF01), 0,0, 0,0, 1,12,32'hFF01, DB,DB, 2,32'h314,32'h100, 0,0, 5};
      tbl[23] = '{0, '0, 0,0, 0,0, 0,0,0, DB,DB, 32'hFF01,32'h314,32'h100, 0,0, 6};
      tbl[24] = '{1, mkb(0,0,0,0,0,1,0,0), 1,1, 32'h200,0, 0,0,0, DB,DB, 32'hFF01,32'h314,32'h100, 0,0, 6};
      tbl[25] = '{0, '0, 0,0, 0,0, 0,0,0, DB,DB, 32'hFF03,32'h310,32'h200, 1,VEC, 6};
      tbl[26] = '{0, '0, 0,0, 0,0, 0,0,0, DB,DB, 32'hFF03,32'h310,32'h200, 0,0, 6};

      resetn = 0;
      idle();
      step();
      step();
      check_reset("rst");
      resetn = 1;

      for (int i = 0; i < 27; i++) begin
         mem_valid = tbl[i].mv; MEM_WB_BUS = tbl[i].bus; adel = tbl[i].adel; ades = tbl[i].ades;
         epc = tbl[i].epc; e_addr = tbl[i].eaddr;
         step();
         chk($sformatf("v%0d_rf_wen", i), rf_wen, tbl[i].rfw);
         if (tbl[i].rfw) begin
            chk($sformatf("v%0d_rf_wdest", i), rf_wdest, tbl[i].wdest);
            chk($sformatf("v%0d_rf_wdata", i), rf_wdata, tbl[i].wdata);
         end
         chk($sformatf("v%0d_hi", i), hi, tbl[i].hi);
         chk($sformatf("v%0d_lo", i), lo, tbl[i].lo);
         chk($sformatf("v%0d_status", i), cp0_status, tbl[i].st);
         chk($sformatf("v%0d_cause", i), cp0_cause, tbl[i].ca);
         chk($sformatf("v%0d_epc", i), cp0_epc, tbl[i].ep);
         chk($sformatf("v%0d_flush", i), flush, tbl[i].fl);
         chk($sformatf("v%0d_allow", i), wb_allow_in, !tbl[i].fl);
         chk($sformatf("v%0d_retired", i), retired, tbl[i].ret);
         if (tbl[i].fl) chk($sformatf("v%0d_flush_pc", i), flush_pc, tbl[i].fpc);
      end

      // Reset arriving while a FLUSH cycle is in progress.
      mem_valid = 1; MEM_WB_BUS = mkb(0,0,0,0,0,1,0,0); epc = 32'h300;
      step();
      idle();
      step();
      chk("rf_flush_entered", flush, 1);
      resetn = 0;
      mem_valid = 1; MEM_WB_BUS = mkb(1,4,0,1,1,0,0,32'h55);
      step();
      check_reset("midflush");
      resetn = 1;
      idle();
      step();
      chk("post_reset_rf_wen", rf_wen, 0);
      chk("post_reset_retired", retired, 0);

      for (int n = 0; n < 800; n++) begin
         logic [4:0] dest;
         int sel;
         sel = $urandom_range(0, 7);
         dest = (sel == 0) ? 5'd8 : (sel == 1) ? 5'd12 : (sel == 2) ? 5'd13 :
                (sel == 3) ? 5'd14 : 5'($urandom);
         resetn     = ($urandom_range(0, 99) != 0);
         mem_valid  = ($urandom_range(0, 3) != 0);
         MEM_WB_BUS = mkb(1'($urandom), dest, $urandom_range(0, 3) == 0,
                          $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                          $urandom_range(0, 15) == 0, $urandom_range(0, 11) == 0, $urandom);
         adel   = ($urandom_range(0, 19) == 0);
         ades   = ($urandom_range(0, 19) == 0);
         epc    = $urandom;
         e_addr = $urandom;
         step();
         check_model();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
